// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the shared memory port 2.
// slave = arbiter view, master = requesters/memory view.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  r0_req;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic                  r0_gnt;
    logic                  r0_rvalid;
    logic [DATA_WIDTH-1:0] r0_rdata;

    logic                  r1_req;
    logic                  r1_we;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic [DATA_WIDTH-1:0] r1_wdata;
    logic                  r1_gnt;
    logic                  r1_rvalid;
    logic [DATA_WIDTH-1:0] r1_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport slave (
        input  r0_req, r0_addr,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_dout,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_addr, mem_din, mem_we
    );

    modport master (
        output r0_req, r0_addr,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_dout,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for memory port 2 with tagged read-response routing.
// Define ARB_STARVE_GUARD_EN to let requester 1 win after STARVE_LIMIT denied cycles.
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    mem_port_arbiter_if.slave   bus
);
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_starved;
    logic                  w_rsp0;
    logic                  w_rsp1;

    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_din;
    logic                  r_mem_we;

    logic                  r_t1_vld, r_t1_id, r_t1_rd;
    logic                  r_t2_vld, r_t2_id, r_t2_rd;

    logic                  r_r0_rvalid;
    logic [DATA_WIDTH-1:0] r_r0_rdata;
    logic                  r_r1_rvalid;
    logic [DATA_WIDTH-1:0] r_r1_rdata;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] r_starve_cnt;

    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
        end else if (!bus.r1_req || w_gnt1) begin
            r_starve_cnt <= '0;
        end else if (!w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    assign w_starved = 1'b0;
`endif

    // Grants are forced low while reset is asserted so no request is accepted then.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (i_rst_n) begin
            if (bus.r1_req && w_starved) begin
                w_gnt1 = 1'b1;
            end else if (bus.r0_req) begin
                w_gnt0 = 1'b1;
            end else if (bus.r1_req) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_gnt1) begin
                r_mem_addr <= bus.r1_addr;
                r_mem_din  <= bus.r1_wdata;
                r_mem_we   <= bus.r1_we;
            end else if (w_gnt0) begin
                r_mem_addr <= bus.r0_addr;
            end
        end
    end

    // Stage 1 = memory sampling cycle, stage 2 = cycle mem_dout is valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_t1_vld <= 1'b0;
            r_t1_id  <= 1'b0;
            r_t1_rd  <= 1'b0;
            r_t2_vld <= 1'b0;
            r_t2_id  <= 1'b0;
            r_t2_rd  <= 1'b0;
        end else begin
            r_t1_vld <= w_gnt0 | w_gnt1;
            r_t1_id  <= w_gnt1;
            r_t1_rd  <= w_gnt0 | (w_gnt1 & ~bus.r1_we);
            r_t2_vld <= r_t1_vld;
            r_t2_id  <= r_t1_id;
            r_t2_rd  <= r_t1_rd;
        end
    end

    assign w_rsp0 = r_t2_vld & r_t2_rd & ~r_t2_id;
    assign w_rsp1 = r_t2_vld & r_t2_rd &  r_t2_id;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_r0_rvalid <= 1'b0;
            r_r0_rdata  <= '0;
            r_r1_rvalid <= 1'b0;
            r_r1_rdata  <= '0;
        end else begin
            r_r0_rvalid <= w_rsp0;
            r_r1_rvalid <= w_rsp1;
            if (w_rsp0) begin
                r_r0_rdata <= bus.mem_dout;
            end
            if (w_rsp1) begin
                r_r1_rdata <= bus.mem_dout;
            end
        end
    end

    assign bus.r0_gnt    = w_gnt0;
    assign bus.r1_gnt    = w_gnt1;
    assign bus.r0_rvalid = r_r0_rvalid;
    assign bus.r0_rdata  = r_r0_rdata;
    assign bus.r1_rvalid = r_r1_rvalid;
    assign bus.r1_rdata  = r_r1_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_din   = r_mem_din;
    assign bus.mem_we    = r_mem_we;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a write-first synchronous memory model.
// Expectations for the starvation run follow ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    logic mem_clr;
    int   n_chk;
    int   n_err;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    mem_port_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

    mem_port_arbiter #(
        .DATA_WIDTH  (16),
        .ADDR_WIDTH  (16),
        .STARVE_LIMIT(8)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        return {a[7:0], ~a[7:0]};
    endfunction

    logic [15:0] mem_q [256];
    logic        mem_w [256];
    logic [15:0] mem_dout_r;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem_w[i] <= 1'b0;
        end else if (bus.mem_we) begin
            mem_w[bus.mem_addr[7:0]] <= 1'b1;
            mem_q[bus.mem_addr[7:0]] <= bus.mem_din;
        end
        if (bus.mem_we)
            mem_dout_r <= bus.mem_din;
        else if (!mem_clr && mem_w[bus.mem_addr[7:0]])
            mem_dout_r <= mem_q[bus.mem_addr[7:0]];
        else
            mem_dout_r <= init_val(bus.mem_addr);
    end
    assign bus.mem_dout = mem_dout_r;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.r0_req   = 1'b0;
        bus.r0_addr  = '0;
        bus.r1_req   = 1'b0;
        bus.r1_we    = 1'b0;
        bus.r1_addr  = '0;
        bus.r1_wdata = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt0"},  {31'd0, bus.r0_gnt},    32'd0);
        chk({tag, "_gnt1"},  {31'd0, bus.r1_gnt},    32'd0);
        chk({tag, "_rv0"},   {31'd0, bus.r0_rvalid}, 32'd0);
        chk({tag, "_rv1"},   {31'd0, bus.r1_rvalid}, 32'd0);
        chk({tag, "_rd0"},   {16'd0, bus.r0_rdata},  32'd0);
        chk({tag, "_rd1"},   {16'd0, bus.r1_rdata},  32'd0);
        chk({tag, "_we"},    {31'd0, bus.mem_we},    32'd0);
        chk({tag, "_addr"},  {16'd0, bus.mem_addr},  32'd0);
        chk({tag, "_din"},   {16'd0, bus.mem_din},   32'd0);
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        mem_clr = 1'b1;
        idle();
        bus.r0_req = 1'b1;
        repeat (3) nxt();
        chk_all_zero("reset");
        mem_clr = 1'b0;
        idle();
        rst_n = 1'b1;
        nxt();

        // r0 read of 0x0010
        bus.r0_req = 1'b1; bus.r0_addr = 16'h0010;
        #1;
        chk("a_gnt0", {31'd0, bus.r0_gnt}, 32'd1);
        chk("a_gnt1", {31'd0, bus.r1_gnt}, 32'd0);
        nxt(); idle(); #1;
        chk("a_maddr", {16'd0, bus.mem_addr}, 32'h0010);
        chk("a_mwe",   {31'd0, bus.mem_we},   32'd0);
        chk("a_rv0_c1", {31'd0, bus.r0_rvalid}, 32'd0);
        nxt();
        chk("a_rv0_c2", {31'd0, bus.r0_rvalid}, 32'd0);
        nxt();
        chk("a_rv0_c3", {31'd0, bus.r0_rvalid}, 32'd1);
        chk("a_rd0",    {16'd0, bus.r0_rdata},  32'hBEEF);
        chk("a_rv1_c3", {31'd0, bus.r1_rvalid}, 32'd0);
        nxt();
        chk("a_rv0_c4", {31'd0, bus.r0_rvalid}, 32'd0);
        chk("a_rd0_hold", {16'd0, bus.r0_rdata}, 32'hBEEF);

        // r1 write 0x1234 -> 0x0020, then read back
        bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 16'h0020; bus.r1_wdata = 16'h1234;
        #1;
        chk("b_gnt1_w", {31'd0, bus.r1_gnt}, 32'd1);
        nxt(); bus.r1_we = 1'b0; bus.r1_wdata = 16'h0000; #1;
        chk("b_gnt1_r", {31'd0, bus.r1_gnt}, 32'd1);
        chk("b_mwe_c1", {31'd0, bus.mem_we},  32'd1);
        chk("b_maddr",  {16'd0, bus.mem_addr}, 32'h0020);
        chk("b_mdin",   {16'd0, bus.mem_din},  32'h1234);
        nxt(); idle(); #1;
        chk("b_mwe_c2", {31'd0, bus.mem_we}, 32'd0);
        chk("b_rv1_c2", {31'd0, bus.r1_rvalid}, 32'd0);
        nxt();
        chk("b_rv1_c3", {31'd0, bus.r1_rvalid}, 32'd0);
        nxt();
        chk("b_rv1_c4", {31'd0, bus.r1_rvalid}, 32'd1);
        chk("b_rd1",    {16'd0, bus.r1_rdata},  32'h1234);
        chk("b_rv0_c4", {31'd0, bus.r0_rvalid}, 32'd0);
        nxt();
        chk("b_rv1_c5", {31'd0, bus.r1_rvalid}, 32'd0);

        // interleaved reads r0, r1, r0
        bus.r0_req = 1'b1; bus.r0_addr = 16'h0030;
        #1; chk("c_gnt0_0", {31'd0, bus.r0_gnt}, 32'd1);
        nxt(); idle(); bus.r1_req = 1'b1; bus.r1_addr = 16'h0040;
        #1; chk("c_gnt1_1", {31'd0, bus.r1_gnt}, 32'd1);
        chk("c_gnt0_1", {31'd0, bus.r0_gnt}, 32'd0);
        nxt(); idle(); bus.r0_req = 1'b1; bus.r0_addr = 16'h0050;
        #1; chk("c_gnt0_2", {31'd0, bus.r0_gnt}, 32'd1);
        nxt(); idle(); #1;
        chk("c_rv0_3", {31'd0, bus.r0_rvalid}, 32'd1);
        chk("c_rd0_3", {16'd0, bus.r0_rdata},  {16'd0, init_val(16'h0030)});
        chk("c_rv1_3", {31'd0, bus.r1_rvalid}, 32'd0);
        nxt();
        chk("c_rv1_4", {31'd0, bus.r1_rvalid}, 32'd1);
        chk("c_rd1_4", {16'd0, bus.r1_rdata},  {16'd0, init_val(16'h0040)});
        chk("c_rv0_4", {31'd0, bus.r0_rvalid}, 32'd0);
        chk("c_rd0_4", {16'd0, bus.r0_rdata},  {16'd0, init_val(16'h0030)});
        nxt();
        chk("c_rv0_5", {31'd0, bus.r0_rvalid}, 32'd1);
        chk("c_rd0_5", {16'd0, bus.r0_rdata},  {16'd0, init_val(16'h0050)});
        chk("c_rv1_5", {31'd0, bus.r1_rvalid}, 32'd0);
        nxt();

        // r1 write request held 3 cycles then dropped while r0 owns the port
        bus.r0_req = 1'b1; bus.r0_addr = 16'h0060;
        bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 16'h0070; bus.r1_wdata = 16'hDEAD;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("d_gnt1_%0d", k), {31'd0, bus.r1_gnt}, 32'd0);
            chk($sformatf("d_gnt0_%0d", k), {31'd0, bus.r0_gnt}, 32'd1);
            nxt();
        end
        bus.r1_req = 1'b0; bus.r1_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("d_mwe_%0d", k), {31'd0, bus.mem_we}, 32'd0);
            nxt();
        end

        // both requesting continuously: r1 wins every 9th cycle only with the guard
        bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 16'h0080;
        for (int k = 1; k <= 27; k++) begin
            #1;
            chk($sformatf("e_gnt1_%0d", k), {31'd0, bus.r1_gnt},
                {31'd0, (GUARD && (k % 9 == 0))});
            chk($sformatf("e_gnt0_%0d", k), {31'd0, bus.r0_gnt},
                {31'd0, !(GUARD && (k % 9 == 0))});
            nxt();
        end
        idle();
        repeat (4) nxt();

        // reset with reads in flight
        bus.r0_req = 1'b1; bus.r0_addr = 16'h0010;
        nxt(); idle(); bus.r1_req = 1'b1; bus.r1_addr = 16'h0020;
        nxt(); idle(); bus.r0_req = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("f_rst");
        nxt(); nxt();
        idle();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("f_rv0_%0d", k), {31'd0, bus.r0_rvalid}, 32'd0);
            chk($sformatf("f_rv1_%0d", k), {31'd0, bus.r1_rvalid}, 32'd0);
            chk($sformatf("f_mwe_%0d", k), {31'd0, bus.mem_we},    32'd0);
            nxt();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares port 2 (addr2/dataIn2/we2/dataOut2) of the dual-port memory block between the display scan-out reader (requester 0, read-only, high priority) and the game-logic engine (requester 1, read/write). It issues at most one memory access per cycle, pipelines accesses through the memory's one-cycle synchronous read, tags each access and routes returned read data back to the requester that issued it. It sits between the two masters and the memory, and drives the memory port directly.

## Interface
- DATA_WIDTH, 16, memory word width
- ADDR_WIDTH, 16, memory address width
- STARVE_LIMIT, 8, consecutive denied cycles after which requester 1 beats requester 0 (1..255)

- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- r0_req  in  1  requester 0 read request; held with r0_addr until r0_gnt
- r0_addr  in  ADDR_WIDTH  requester 0 read address
- r0_gnt  out  1  combinational; request accepted this cycle
- r0_rvalid  out  1  registered; r0_rdata valid this cycle (one-cycle pulse per read)
- r0_rdata  out  DATA_WIDTH  registered read data for requester 0
- r1_req  in  1  requester 1 request; held with r1_we/r1_addr/r1_wdata until r1_gnt
- r1_we  in  1  1 = write, 0 = read
- r1_addr  in  ADDR_WIDTH  requester 1 address
- r1_wdata  in  DATA_WIDTH  requester 1 write data
- r1_gnt  out  1  combinational; request accepted this cycle
- r1_rvalid  out  1  registered; r1_rdata valid (reads only)
- r1_rdata  out  DATA_WIDTH  registered read data for requester 1
- mem_addr  out  ADDR_WIDTH  registered; to memory addr2
- mem_din  out  DATA_WIDTH  registered; to memory dataIn2
- mem_we  out  1  registered; to memory we2
- mem_dout  in  DATA_WIDTH  from memory dataOut2

## Operation
- Arbitration each cycle: if r1_req and starve count == STARVE_LIMIT, grant r1; else if r0_req, grant r0; else if r1_req, grant r1; else no grant. At most one of r0_gnt/r1_gnt high.
- On a grant edge: mem_addr/mem_din/mem_we load from the winner (r0 always mem_we=0, mem_din unchanged); issue tag {valid, id, is_read} enters stage 1.
- No grant: mem_we <= 0; mem_addr and mem_din hold last value; stage-1 tag invalid.
- Tag pipeline: stage 1 (memory sampling cycle) -> stage 2 (mem_dout valid cycle). At the edge ending stage 2, a valid read tag loads mem_dout into rN_rdata and pulses rN_rvalid for the tag's id. Writes produce no response.
- rN_rdata holds its last value between responses.
- Starve counter (width clog2(STARVE_LIMIT+1)): +1 each cycle r1_req && !r1_gnt, saturating at STARVE_LIMIT; cleared when r1_gnt or !r1_req.
- Dropping rN_req before grant is legal; no access issued, counter clears for r1.
- Ordering: single in-order port; a write followed by a read of the same address in the next grant returns the written data (memory is write-first).

## Timing
- Reset (rst_n low, async): mem_we=0, mem_addr=0, mem_din=0, both rvalid=0, both rdata=0, tags invalid, starve count=0. gnt outputs are 0 while rst_n is low.
- Reset mid-operation: in-flight tags discarded; no rvalid after deassertion for accesses granted before reset.
- Read latency: grant in cycle C -> memory samples at end of C+1 -> rvalid/rdata high in cycle C+3.
- Throughput: one access per cycle; back-to-back grants to either requester allowed, responses return in grant order, one per cycle.
- Write takes effect at the end of cycle C+1.

## Configuration
- ARB_STARVE_GUARD_EN defined: starve counter and STARVE_LIMIT override active as above.
- Not defined: counter removed; strict fixed priority, r0 always wins; STARVE_LIMIT ignored.

## Test plan
- Reset: rst_n low mid-read with tags in flight -> all outputs 0, no rvalid after release, mem_we stays 0.
- r0 read addr 0x0010 (mem holds 0xBEEF), grant cycle C -> r0_rvalid one pulse in C+3 with r0_rdata=0xBEEF, r1_rvalid stays 0.
- r1 write 0x1234 to 0x0020 granted cycle C, r1 read 0x0020 granted C+1 -> mem_we high in C+1 only, r1_rvalid in C+4 with 0x1234.
- r0 and r1 requesting continuously, STARVE_LIMIT=8, guard enabled -> r1 granted in its 9th waiting cycle, then r0 for next 8; pattern repeats; disabled build -> r1 never granted.
- Interleaved grants r0,r1,r0 (all reads, distinct data) in consecutive cycles -> rvalid pulses r0,r1,r0 in consecutive cycles with matching data, no cross-routing.
- r1_req raised 3 cycles then dropped while r0 holds bus -> no r1 access, counter returns to 0, no mem_we.
